// File: rtl/dbg_trace_pkg.sv
// Shared definitions for the debug trace recorder: record layout, type codes and a packing helper.
package dbg_trace_pkg;

    localparam int REC_W    = 34;
    localparam int TYPE_MSB = 33;
    localparam int TYPE_LSB = 32;
    localparam int PC_MSB   = 31;
    localparam int PC_LSB   = 24;
    localparam int ADDR_MSB = 23;
    localparam int ADDR_LSB = 16;
    localparam int DATA_MSB = 15;
    localparam int DATA_LSB = 0;

    typedef logic [1:0]       rec_type_t;
    typedef logic [REC_W-1:0] rec_t;

    localparam rec_type_t TYPE_REG_WR = 2'b00;
    localparam rec_type_t TYPE_RAM_WR = 2'b01;
    localparam rec_type_t TYPE_DROP   = 2'b11;

    function automatic rec_t pack_rec(input rec_type_t t, input logic [7:0] pc,
                                      input logic [7:0] addr, input logic [15:0] data);
        rec_t r;
        r                    = '0;
        r[TYPE_MSB:TYPE_LSB] = t;
        r[PC_MSB:PC_LSB]     = pc;
        r[ADDR_MSB:ADDR_LSB] = addr;
        r[DATA_MSB:DATA_LSB] = data;
        return r;
    endfunction

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Two-write / one-read FIFO for trace records; up to two pushes and one pop per cycle.
module trace_fifo_2w1r
    import dbg_trace_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push0_i,
    input  logic             push1_i,
    input  rec_t             data0_i,
    input  rec_t             data1_i,
    input  logic             pop_i,
    output rec_t             head_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] count_o
);

    rec_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_p1;
    logic [LVL_W-1:0] count_q, count_d;

    // push1_i is only ever raised together with push0_i, so slot1 always follows slot0.
    always_comb begin
        wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
        wr_ptr_d  = wr_ptr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop_i);
        count_d   = count_q + LVL_W'(push0_i) + LVL_W'(push1_i) - LVL_W'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push0_i) mem_q[wr_ptr_q]  <= data0_i;
        if (push1_i) mem_q[wr_ptr_p1] <= data1_i;
    end

    assign empty_o = (count_q == '0);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/dbg_trace_recorder.sv
// Packs CPU debug-tap writes into trace records, handles overflow with DROP records, buffers them for a reader.
module dbg_trace_recorder
    import dbg_trace_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int CNT_W = 16,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trace_en,
    input  logic [7:0]       DBG_pc,
    input  logic             DBG_wr_rd,
    input  logic [3:0]       DBG_addr_rd,
    input  logic [15:0]      DBG_wdata_rd,
    input  logic             DBG_ram_wr,
    input  logic [7:0]       DBG_ram_waddr,
    input  logic [15:0]      DBG_ram_wdata,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [REC_W-1:0] rd_data,
    output logic [LVL_W-1:0] level,
    output logic             overflow
);

    logic             ev_reg, ev_ram, pop, empty;
    logic [1:0]       n, drop_inc;
    logic [LVL_W:0]   free, n_w;
    rec_t             rec_reg, rec_ram, rec_drop, first_rec;
    logic             push0, push1;
    rec_t             data0, data1;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W:0]   drop_sum;
    logic             overflow_q, overflow_d;

    assign ev_reg    = trace_en & DBG_wr_rd;
    assign ev_ram    = trace_en & DBG_ram_wr;
    assign n         = {1'b0, ev_reg} + {1'b0, ev_ram};
    assign n_w       = (LVL_W+1)'(n);
    assign pop       = rd_valid & rd_ready;
    // A same-cycle pop frees its slot for this cycle's pushes.
    assign free      = (LVL_W+1)'(DEPTH) - {1'b0, level} + (LVL_W+1)'(pop);

    assign rec_reg   = pack_rec(TYPE_REG_WR, DBG_pc, {4'h0, DBG_addr_rd}, DBG_wdata_rd);
    assign rec_ram   = pack_rec(TYPE_RAM_WR, DBG_pc, DBG_ram_waddr, DBG_ram_wdata);
    assign rec_drop  = pack_rec(TYPE_DROP, 8'h00, 8'h00, 16'(drop_cnt_q));
    assign first_rec = ev_reg ? rec_reg : rec_ram;

    always_comb begin
        push0      = 1'b0;
        push1      = 1'b0;
        data0      = first_rec;
        data1      = rec_ram;
        drop_inc   = 2'd0;
        drop_sum   = '0;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (drop_cnt_q == '0) begin
            if (free >= n_w) begin
                push0 = (n != 2'd0);
                push1 = (n == 2'd2);
            end else begin
                // Fewer free slots than events: REG_WR takes the one slot if any.
                push0    = (free != '0);
                drop_inc = n - free[1:0];
            end
        end else if (free >= n_w + (LVL_W+1)'(1)) begin
            // DROP record goes first; with two events the write port cap defers RAM_WR into a new drop.
            push0      = 1'b1;
            data0      = rec_drop;
            push1      = (n != 2'd0);
            data1      = first_rec;
            drop_cnt_d = (n == 2'd2) ? CNT_W'(1) : '0;
        end else begin
            drop_inc = n;
        end
        if (drop_inc != 2'd0) begin
            drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(drop_inc);
            drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    trace_fifo_2w1r #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push0_i (push0),
        .push1_i (push1),
        .data0_i (data0),
        .data1_i (data1),
        .pop_i   (pop),
        .head_o  (rd_data),
        .empty_o (empty),
        .count_o (level)
    );

    assign rd_valid = ~empty;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_dbg_trace_recorder.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_dbg_trace_recorder;

    localparam int DEPTH   = 16;
    localparam int CNT_W   = 16;
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_en;
    logic [7:0]  DBG_pc;
    logic        DBG_wr_rd;
    logic [3:0]  DBG_addr_rd;
    logic [15:0] DBG_wdata_rd;
    logic        DBG_ram_wr;
    logic [7:0]  DBG_ram_waddr;
    logic [15:0] DBG_ram_wdata;
    logic        rd_valid;
    logic        rd_ready;
    logic [33:0] rd_data;
    logic [LVL_W-1:0] level;
    logic        overflow;

    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;

    dbg_trace_recorder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .trace_en      (trace_en),
        .DBG_pc        (DBG_pc),
        .DBG_wr_rd     (DBG_wr_rd),
        .DBG_addr_rd   (DBG_addr_rd),
        .DBG_wdata_rd  (DBG_wdata_rd),
        .DBG_ram_wr    (DBG_ram_wr),
        .DBG_ram_waddr (DBG_ram_waddr),
        .DBG_ram_wdata (DBG_ram_wdata),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .level         (level),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [33:0] mk(input logic [1:0] t, input logic [7:0] pc,
                                       input logic [7:0] addr, input logic [15:0] data);
        return {t, pc, addr, data};
    endfunction

    // Reference model: the FIFO is a queue, admission follows the drop rules directly.
    logic [33:0] m_q[$];
    logic [33:0] m_evs[$];
    logic [33:0] m_push[$];
    int          m_drop = 0;
    bit          m_ovf  = 1'b0;

    always @(posedge clk) begin
        int n, free;
        bit pop;
        if (rst) begin
            m_q.delete();
            m_drop = 0;
            m_ovf  = 1'b0;
        end else begin
            m_evs.delete();
            m_push.delete();
            if (trace_en && DBG_wr_rd)  m_evs.push_back(mk(2'b00, DBG_pc, {4'h0, DBG_addr_rd}, DBG_wdata_rd));
            if (trace_en && DBG_ram_wr) m_evs.push_back(mk(2'b01, DBG_pc, DBG_ram_waddr, DBG_ram_wdata));
            n    = m_evs.size();
            pop  = (m_q.size() != 0) && rd_ready;
            free = DEPTH - m_q.size() + int'(pop);
            if (m_drop == 0) begin
                for (int i = 0; i < n; i++) begin
                    if (i < free) m_push.push_back(m_evs[i]);
                    else begin
                        m_drop = (m_drop < CNT_MAX) ? m_drop + 1 : CNT_MAX;
                        m_ovf  = 1'b1;
                    end
                end
            end else if (free >= n + 1) begin
                m_push.push_back(mk(2'b11, 8'h00, 8'h00, 16'(m_drop)));
                if (n >= 1) m_push.push_back(m_evs[0]);
                m_drop = (n == 2) ? 1 : 0;
            end else if (n > 0) begin
                m_drop = (m_drop + n > CNT_MAX) ? CNT_MAX : m_drop + n;
                m_ovf  = 1'b1;
            end
            if (pop) void'(m_q.pop_front());
            foreach (m_push[i]) m_q.push_back(m_push[i]);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_valid", 64'(rd_valid), 64'(m_q.size() != 0));
            check("cmp_level", 64'(level), 64'(m_q.size()));
            check("cmp_overflow", 64'(overflow), 64'(m_ovf));
            check("cmp_data", 64'(rd_data), (m_q.size() != 0) ? 64'(m_q[0]) : 64'd0);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_taps();
        DBG_wr_rd  = 1'b0;
        DBG_ram_wr = 1'b0;
    endtask

    task automatic reg_wr(input logic [7:0] pc, input logic [3:0] a, input logic [15:0] d);
        DBG_pc = pc; DBG_wr_rd = 1'b1; DBG_addr_rd = a; DBG_wdata_rd = d;
    endtask

    task automatic ram_wr(input logic [7:0] pc, input logic [7:0] a, input logic [15:0] d);
        DBG_pc = pc; DBG_ram_wr = 1'b1; DBG_ram_waddr = a; DBG_ram_wdata = d;
    endtask

    initial begin
        rst = 1'b1; trace_en = 1'b1; rd_ready = 1'b0;
        DBG_pc = '0; DBG_addr_rd = '0; DBG_wdata_rd = '0; DBG_ram_waddr = '0; DBG_ram_wdata = '0;
        idle_taps();
        cycle(); cycle();
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_valid", 64'(rd_valid), 64'd0);
        check("reset_data", 64'(rd_data), 64'd0);
        check("reset_level", 64'(level), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);

        // Single register write.
        reg_wr(8'h12, 4'd3, 16'h00A5);
        cycle(); idle_taps();
        check("single_data", 64'(rd_data), 64'h0_1203_00A5);
        check("single_level", 64'(level), 64'd1);
        rd_ready = 1'b1; cycle(); rd_ready = 1'b0;

        // Dual event in one cycle: REG_WR first.
        reg_wr(8'h20, 4'd5, 16'h1111);
        ram_wr(8'h20, 8'h40, 16'h2222);
        cycle(); idle_taps();
        check("dual_first", 64'(rd_data), 64'h0_2005_1111);
        check("dual_level", 64'(level), 64'd2);
        rd_ready = 1'b1; cycle();
        check("dual_second", 64'(rd_data), 64'h1_2040_2222);
        cycle(); rd_ready = 1'b0;
        check("dual_drained", 64'(level), 64'd0);

        // Fill past capacity, then recover with a DROP record.
        for (int i = 0; i < 18; i++) begin
            reg_wr(8'(i), 4'(i), 16'(i));
            cycle();
        end
        idle_taps();
        check("fill_level", 64'(level), 64'd16);
        check("fill_overflow", 64'(overflow), 64'd1);
        rd_ready = 1'b1; cycle();
        check("drop_push_level", 64'(level), 64'd16);
        reg_wr(8'h77, 4'd9, 16'hBEEF);
        cycle(); idle_taps();
        check("post_drop_level", 64'(level), 64'd16);
        for (int i = 2; i < 16; i++) begin
            check("survivor", 64'(rd_data), 64'(mk(2'b00, 8'(i), 8'(i), 16'(i))));
            cycle();
        end
        check("drop_record", 64'(rd_data), 64'h3_0000_0002);
        cycle();
        check("after_drop_event", 64'(rd_data), 64'h0_7709_BEEF);
        cycle(); rd_ready = 1'b0;
        check("recover_drained", 64'(level), 64'd0);

        // Reset mid-operation at level 7.
        for (int i = 0; i < 7; i++) begin
            ram_wr(8'(8'h30 + i), 8'(i), 16'(16'hA000 + i));
            cycle();
        end
        check("pre_rst_level", 64'(level), 64'd7);
        rst = 1'b1; cycle();
        rst = 1'b0; idle_taps();
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        ram_wr(8'h9A, 8'h55, 16'h1234);
        cycle(); idle_taps();
        check("post_rst_head", 64'(rd_data), 64'h1_9A55_1234);
        check("post_rst_level", 64'(level), 64'd1);

        // Taps ignored while trace_en is low.
        trace_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            reg_wr(8'($urandom), 4'($urandom), 16'($urandom));
            ram_wr(8'($urandom), 8'($urandom), 16'($urandom));
            cycle();
        end
        idle_taps(); trace_en = 1'b1;
        check("en_off_level", 64'(level), 64'd1);
        check("en_off_overflow", 64'(overflow), 64'd0);
        rd_ready = 1'b1; cycle(); rd_ready = 1'b0;

        // Full FIFO with simultaneous pop and push across pointer wrap.
        for (int i = 0; i < 16; i++) begin
            reg_wr(8'(i), 4'(i), 16'(16'h5000 + i));
            cycle();
        end
        idle_taps();
        rd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i[0]) ram_wr(8'(8'h80 + i), 8'(i), 16'(16'h6000 + i));
            else      reg_wr(8'(8'h80 + i), 4'(i), 16'(16'h6000 + i));
            cycle(); idle_taps();
            check("wrap_level", 64'(level), 64'd16);
        end
        for (int i = 0; i < 16; i++) cycle();
        rd_ready = 1'b0;
        check("wrap_drained", 64'(level), 64'd0);

        // Randomized traffic with varying reader pressure and rare resets.
        for (int i = 0; i < 4000; i++) begin
            int bias;
            bias = 10 + 20 * ((i / 500) % 5);
            trace_en = ($urandom_range(0, 9) != 0);
            idle_taps();
            if ($urandom_range(0, 1) == 1) reg_wr(8'($urandom), 4'($urandom), 16'($urandom));
            if ($urandom_range(0, 1) == 1) ram_wr(8'($urandom), 8'($urandom), 16'($urandom));
            rd_ready = ($urandom_range(0, 99) < bias);
            rst      = ($urandom_range(0, 399) == 0);
            cycle();
        end
        rst = 1'b0; idle_taps(); rd_ready = 1'b1;
        for (int i = 0; i < 40; i++) cycle();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
